hovalaag_slot_sequencer: RTL and testbench

- Time-multiplexes the narrow pin bus between the Tiny Tapeout top and the Hovalaag core.
- Runs a free-running slot counter. Assembles NUM_SLOTS input chunks of CHUNK_W bits into one frame and hands it to the core over a valid/ready handshake.
- Serialises a latched core output word plus a status byte onto the 8-bit output pins, one byte per slot.
- Replaces the ad-hoc slot address counter at the top level.

---
 rtl/hovalaag_seq_pkg.sv | 19 +
 rtl/hovalaag_slot_sequencer_if.sv | 39 +++
 rtl/hovalaag_frame_buffer.sv | 102 ++++++++++
 rtl/hovalaag_slot_sequencer.sv | 137 +++++++++++++
 tb/tb_hovalaag_slot_sequencer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/hovalaag_seq_pkg.sv
// Shared definitions for the Hovalaag slot sequencer.
//   SLOT_W              width of the slot index bus
//   STAT_OVR/FV/SV      bit positions of overrun, frame_valid and
//                       shadow_valid in the slot-0 status byte
//   buf_state_e         occupancy of the one-entry frame buffer
package hovalaag_seq_pkg;

  localparam int SLOT_W   = 3;

  localparam int STAT_OVR = 7;
  localparam int STAT_FV  = 6;
  localparam int STAT_SV  = 5;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/hovalaag_slot_sequencer_if.sv
// Pin-bus / core-handshake bundle of the slot sequencer.
//   master : drives restart, pin_data, frame_ready, out_word, out_valid,
//            clear_overrun (Tiny Tapeout top plus Hovalaag core side)
//   slave  : drives pin_out, slot, frame_data, frame_valid, out_ack,
//            overrun (the sequencer itself)
interface hovalaag_slot_sequencer_if
  import hovalaag_seq_pkg::*;
#(
  parameter int NUM_SLOTS = 5,
  parameter int CHUNK_W   = 6
) ();

  localparam int FRAME_W    = NUM_SLOTS * CHUNK_W;
  localparam int OUT_WORD_W = (NUM_SLOTS - 1) * 8;

  logic                  restart;
  logic [CHUNK_W-1:0]    pin_data;
  logic [7:0]            pin_out;
  logic [SLOT_W-1:0]     slot;
  logic [FRAME_W-1:0]    frame_data;
  logic                  frame_valid;
  logic                  frame_ready;
  logic [OUT_WORD_W-1:0] out_word;
  logic                  out_valid;
  logic                  out_ack;
  logic                  overrun;
  logic                  clear_overrun;

  modport master (
    output restart, pin_data, frame_ready, out_word, out_valid, clear_overrun,
    input  pin_out, slot, frame_data, frame_valid, out_ack, overrun
  );

  modport slave (
    input  restart, pin_data, frame_ready, out_word, out_valid, clear_overrun,
    output pin_out, slot, frame_data, frame_valid, out_ack, overrun
  );

endinterface

// File: rtl/hovalaag_frame_buffer.sv
// One-entry holding register between frame assembly and the core.
//   clk, reset        clock, asynchronous active-high reset
//   load_i            a complete frame is offered this cycle
//   load_data_i       that frame
//   ready_i           core consumes the held frame
//   clear_overrun_i   clears the sticky overrun flag
//   data_o, valid_o   held frame and its valid flag
//   overrun_o         sticky: a completed frame was dropped
//   valid_next_o,
//   overrun_next_o    values the flags take after the coming edge
module hovalaag_frame_buffer
  import hovalaag_seq_pkg::*;
#(
  parameter int FRAME_W = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic [FRAME_W-1:0] load_data_i,
  input  logic               ready_i,
  input  logic               clear_overrun_i,
  output logic [FRAME_W-1:0] data_o,
  output logic               valid_o,
  output logic               overrun_o,
  output logic               valid_next_o,
  output logic               overrun_next_o
);

  buf_state_e         state_q, state_d;
  logic [FRAME_W-1:0] data_q, data_d;
  logic               overrun_q, overrun_d;
  logic               drop_s;

  // Occupancy, data and overrun next-state logic.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    overrun_d = overrun_q;
    drop_s    = 1'b0;
    case (state_q)
      BUF_EMPTY: begin
        // A ready pulse while empty has nothing to consume.
        if (load_i) begin
          state_d = BUF_FULL;
          data_d  = load_data_i;
        end else begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (ready_i) begin
          // Consume and refill in one edge: the slot frees exactly as
          // the new frame arrives, so nothing is lost.
          if (load_i) begin
            state_d = BUF_FULL;
            data_d  = load_data_i;
          end else begin
            state_d = BUF_EMPTY;
          end
        end else begin
          // Old frame is kept; the newly completed one is discarded.
          if (load_i) begin
            drop_s = 1'b1;
          end else begin
            drop_s = 1'b0;
          end
        end
      end
      default: begin
        state_d = BUF_EMPTY;
      end
    endcase
    // A drop in the same cycle outranks a clear request.
    if (drop_s) begin
      overrun_d = 1'b1;
    end else if (clear_overrun_i) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= BUF_EMPTY;
      data_q    <= {FRAME_W{1'b0}};
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o         = data_q;
  assign valid_o        = (state_q == BUF_FULL);
  assign overrun_o      = overrun_q;
  assign valid_next_o   = (state_d == BUF_FULL);
  assign overrun_next_o = overrun_d;

endmodule

// File: rtl/hovalaag_slot_sequencer.sv
// Time-multiplexes the narrow Tiny Tapeout pin bus onto the Hovalaag core.
// A free-running slot counter gathers NUM_SLOTS chunks of CHUNK_W input
// bits into one frame for the core, and plays the latched core result
// back one byte per slot, with a status byte in slot 0.
//   clk, reset   clock, asynchronous active-high reset
//   bus (slave)  restart, pin_data/pin_out, slot, frame_data/valid/ready,
//                out_word/valid/ack, overrun/clear_overrun
module hovalaag_slot_sequencer
  import hovalaag_seq_pkg::*;
#(
  parameter int NUM_SLOTS = 5,
  parameter int CHUNK_W   = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  hovalaag_slot_sequencer_if.slave  bus
);

  localparam int                FRAME_W    = NUM_SLOTS * CHUNK_W;
  localparam int                OUT_WORD_W = (NUM_SLOTS - 1) * 8;
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(NUM_SLOTS - 1);

  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [FRAME_W-1:0]    asm_q, asm_d;
  logic [OUT_WORD_W-1:0] shadow_q, shadow_d;
  logic                  shadow_valid_q, shadow_valid_d;
  logic [7:0]            pin_out_q, pin_out_d;
  logic                  last_slot_s;
  logic                  complete_s;
  logic                  out_ack_s;
  logic [FRAME_W-1:0]    fb_data_s;
  logic                  fb_valid_s;
  logic                  fb_overrun_s;
  logic                  fb_valid_next_s;
  logic                  fb_overrun_next_s;

  // Slot counter next state; restart resynchronises to slot 0.
  always_comb begin
    last_slot_s = (slot_q == SLOT_LAST);
    complete_s  = last_slot_s && !bus.restart;
    out_ack_s   = bus.out_valid && last_slot_s && !bus.restart;
    if (bus.restart) begin
      slot_d = {SLOT_W{1'b0}};
    end else if (last_slot_s) begin
      slot_d = {SLOT_W{1'b0}};
    end else begin
      slot_d = slot_q + {{(SLOT_W-1){1'b0}}, 1'b1};
    end
  end

  // Chunk assembly. asm_d already holds the last chunk, so the frame
  // buffer can load a complete frame on the completing edge.
  always_comb begin
    asm_d = asm_q;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (!bus.restart && (slot_q == SLOT_W'(k))) begin
        asm_d[k*CHUNK_W +: CHUNK_W] = bus.pin_data;
      end else begin
        asm_d[k*CHUNK_W +: CHUNK_W] = asm_q[k*CHUNK_W +: CHUNK_W];
      end
    end
  end

  // Core result capture; a silent last slot invalidates but keeps data.
  always_comb begin
    shadow_d       = shadow_q;
    shadow_valid_d = shadow_valid_q;
    if (out_ack_s) begin
      shadow_d       = bus.out_word;
      shadow_valid_d = 1'b1;
    end else if (last_slot_s && !bus.out_valid) begin
      shadow_valid_d = 1'b0;
    end else begin
      shadow_valid_d = shadow_valid_q;
    end
  end

  // Output byte for the slot that starts after this edge, built from the
  // post-edge flag and shadow values so the status byte is never stale.
  always_comb begin
    pin_out_d = 8'h00;
    if (slot_d == {SLOT_W{1'b0}}) begin
      pin_out_d[STAT_OVR] = fb_overrun_next_s;
      pin_out_d[STAT_FV]  = fb_valid_next_s;
      pin_out_d[STAT_SV]  = shadow_valid_d;
    end else begin
      for (int k = 1; k < NUM_SLOTS; k++) begin
        if (slot_d == SLOT_W'(k)) begin
          pin_out_d = shadow_d[(k-1)*8 +: 8];
        end else begin
          pin_out_d = pin_out_d;
        end
      end
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q         <= {SLOT_W{1'b0}};
      asm_q          <= {FRAME_W{1'b0}};
      shadow_q       <= {OUT_WORD_W{1'b0}};
      shadow_valid_q <= 1'b0;
      pin_out_q      <= 8'h00;
    end else begin
      slot_q         <= slot_d;
      asm_q          <= asm_d;
      shadow_q       <= shadow_d;
      shadow_valid_q <= shadow_valid_d;
      pin_out_q      <= pin_out_d;
    end
  end

  hovalaag_frame_buffer #(
    .FRAME_W (FRAME_W)
  ) u_frame_buffer (
    .clk             (clk),
    .reset           (reset),
    .load_i          (complete_s),
    .load_data_i     (asm_d),
    .ready_i         (bus.frame_ready),
    .clear_overrun_i (bus.clear_overrun),
    .data_o          (fb_data_s),
    .valid_o         (fb_valid_s),
    .overrun_o       (fb_overrun_s),
    .valid_next_o    (fb_valid_next_s),
    .overrun_next_o  (fb_overrun_next_s)
  );

  assign bus.slot        = slot_q;
  assign bus.pin_out     = pin_out_q;
  assign bus.frame_data  = fb_data_s;
  assign bus.frame_valid = fb_valid_s;
  assign bus.overrun     = fb_overrun_s;
  assign bus.out_ack     = out_ack_s;

endmodule

// File: tb/tb_hovalaag_slot_sequencer.sv
// Scenario bench for hovalaag_slot_sequencer (NUM_SLOTS=5, CHUNK_W=6).
// Expected frames and playback bytes are queued as stimulus is applied
// and popped when the sequencer is due to present them.
module tb_hovalaag_slot_sequencer;

  logic clk;
  logic reset;

  hovalaag_slot_sequencer_if #(.NUM_SLOTS(5), .CHUNK_W(6)) bus_if ();

  hovalaag_slot_sequencer #(.NUM_SLOTS(5), .CHUNK_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [29:0] exp_frames[$];
  logic [7:0]  exp_bytes[$];
  logic [29:0] cur_frame;
  logic [29:0] want_f;
  logic [7:0]  want_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [5:0] chunk_of(input logic [29:0] f, input int k);
    logic [29:0] t;
    t = f >> (6 * k);
    return t[5:0];
  endfunction

  // One clock: apply inputs, pass the rising edge, settle 1 time unit.
  task automatic cyc(input logic [5:0] pd, input logic rs, input logic rdy);
    bus_if.pin_data    = pd;
    bus_if.restart     = rs;
    bus_if.frame_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input logic [29:0] f, input logic [4:0] rdy_mask);
    for (int k = 0; k < 5; k++) cyc(chunk_of(f, k), 1'b0, rdy_mask[k]);
    bus_if.frame_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus_if.restart = 1'b0; bus_if.pin_data = 6'h00; bus_if.frame_ready = 1'b0;
    bus_if.out_word = 32'h0; bus_if.out_valid = 1'b0; bus_if.clear_overrun = 1'b0;
    #12;
    n_cmp++; if (bus_if.slot !== 3'd0) begin n_err++; $display("FAIL reset_slot: got %0d want 0", bus_if.slot); end
    n_cmp++; if (bus_if.frame_valid !== 1'b0) begin n_err++; $display("FAIL reset_fv: got %b want 0", bus_if.frame_valid); end
    n_cmp++; if (bus_if.frame_data !== 30'h0) begin n_err++; $display("FAIL reset_fdata: got %h want 0", bus_if.frame_data); end
    n_cmp++; if (bus_if.pin_out !== 8'h00) begin n_err++; $display("FAIL reset_pin_out: got %h want 00", bus_if.pin_out); end
    n_cmp++; if (bus_if.overrun !== 1'b0) begin n_err++; $display("FAIL reset_ovr: got %b want 0", bus_if.overrun); end
    reset = 1'b0;
  endtask

  task automatic test_first_frame;
    logic [29:0] f;
    f = {6'd5, 6'd4, 6'd3, 6'd2, 6'd1};
    exp_frames.push_back(f);
    for (int k = 0; k < 4; k++) cyc(chunk_of(f, k), 1'b0, 1'b0);
    n_cmp++; if (bus_if.slot !== 3'd4) begin n_err++; $display("FAIL ff_slot4: got %0d want 4", bus_if.slot); end
    n_cmp++; if (bus_if.frame_valid !== 1'b0) begin n_err++; $display("FAIL ff_early_fv: got %b want 0", bus_if.frame_valid); end
    cyc(chunk_of(f, 4), 1'b0, 1'b0);
    want_f = exp_frames.pop_front();
    cur_frame = want_f;
    n_cmp++; if (bus_if.slot !== 3'd0) begin n_err++; $display("FAIL ff_wrap: got %0d want 0", bus_if.slot); end
    n_cmp++; if (bus_if.frame_valid !== 1'b1) begin n_err++; $display("FAIL ff_fv: got %b want 1", bus_if.frame_valid); end
    n_cmp++; if (bus_if.frame_data !== want_f) begin n_err++; $display("FAIL ff_fdata: got %h want %h", bus_if.frame_data, want_f); end
    n_cmp++; if (bus_if.pin_out !== 8'h40) begin n_err++; $display("FAIL ff_status: got %h want 40", bus_if.pin_out); end
  endtask

  task automatic test_overrun;
    logic [29:0] f;
    f = {6'h15, 6'h2A, 6'h33, 6'h22, 6'h11};
    for (int k = 0; k < 4; k++) cyc(chunk_of(f, k), 1'b0, 1'b0);
    // Drop and clear in the same cycle: the drop must win.
    bus_if.clear_overrun = 1'b1;
    cyc(chunk_of(f, 4), 1'b0, 1'b0);
    bus_if.clear_overrun = 1'b0;
    n_cmp++; if (bus_if.overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %b want 1", bus_if.overrun); end
    n_cmp++; if (bus_if.frame_data !== cur_frame) begin n_err++; $display("FAIL ovr_keep: got %h want %h", bus_if.frame_data, cur_frame); end
    n_cmp++; if (bus_if.frame_valid !== 1'b1) begin n_err++; $display("FAIL ovr_fv: got %b want 1", bus_if.frame_valid); end
    n_cmp++; if (bus_if.pin_out !== 8'hC0) begin n_err++; $display("FAIL ovr_status: got %h want c0", bus_if.pin_out); end
    bus_if.clear_overrun = 1'b1;
    cyc(6'h00, 1'b0, 1'b0);
    bus_if.clear_overrun = 1'b0;
    n_cmp++; if (bus_if.overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %b want 0", bus_if.overrun); end
    cyc(6'h00, 1'b1, 1'b0);
    n_cmp++; if (bus_if.slot !== 3'd0) begin n_err++; $display("FAIL ovr_resync: got %0d want 0", bus_if.slot); end
  endtask

  task automatic test_back_to_back;
    logic [29:0] f;
    f = {6'h3E, 6'h01, 6'h20, 6'h0F, 6'h30};
    exp_frames.push_back(f);
    drive_frame(f, 5'b10000);
    want_f = exp_frames.pop_front();
    cur_frame = want_f;
    n_cmp++; if (bus_if.frame_valid !== 1'b1) begin n_err++; $display("FAIL b2b_fv: got %b want 1", bus_if.frame_valid); end
    n_cmp++; if (bus_if.frame_data !== want_f) begin n_err++; $display("FAIL b2b_fdata: got %h want %h", bus_if.frame_data, want_f); end
    n_cmp++; if (bus_if.overrun !== 1'b0) begin n_err++; $display("FAIL b2b_ovr: got %b want 0", bus_if.overrun); end
    n_cmp++; if (bus_if.pin_out !== 8'h40) begin n_err++; $display("FAIL b2b_status: got %h want 40", bus_if.pin_out); end
  endtask

  task automatic test_out_word;
    logic [29:0] f;
    logic [31:0] w;
    w = 32'hDEADBEEF;
    f = {6'h0C, 6'h0B, 6'h0A, 6'h09, 6'h08};
    exp_frames.push_back(f);
    bus_if.out_valid = 1'b1;
    bus_if.out_word  = w;
    for (int k = 0; k < 5; k++) begin
      bus_if.pin_data    = chunk_of(f, k);
      bus_if.restart     = 1'b0;
      bus_if.frame_ready = (k == 0);
      #1;
      n_cmp++; if (bus_if.out_ack !== (k == 4)) begin n_err++; $display("FAIL ack_slot%0d: got %b want %b", k, bus_if.out_ack, (k == 4)); end
      if (k == 4) for (int b = 0; b < 4; b++) exp_bytes.push_back(8'(w >> (8 * b)));
      @(posedge clk);
      #1;
    end
    bus_if.out_valid = 1'b0;
    bus_if.out_word  = 32'h0;
    want_f = exp_frames.pop_front();
    cur_frame = want_f;
    n_cmp++; if (bus_if.pin_out !== 8'h60) begin n_err++; $display("FAIL ow_status: got %h want 60", bus_if.pin_out); end
    n_cmp++; if (bus_if.frame_data !== want_f) begin n_err++; $display("FAIL ow_fdata: got %h want %h", bus_if.frame_data, want_f); end
    // Playback frame; ready stays high so slots 2..4 see it while empty.
    f = {6'h2F, 6'h1E, 6'h0D, 6'h3C, 6'h2B};
    exp_frames.push_back(f);
    for (int k = 0; k < 4; k++) begin
      cyc(chunk_of(f, k), 1'b0, 1'b1);
      want_b = exp_bytes.pop_front();
      n_cmp++; if (bus_if.pin_out !== want_b) begin n_err++; $display("FAIL ow_byte%0d: got %h want %h", k, bus_if.pin_out, want_b); end
      if (k == 0) begin
        n_cmp++; if (bus_if.frame_valid !== 1'b0) begin n_err++; $display("FAIL ow_consume: got %b want 0", bus_if.frame_valid); end
      end
    end
    cyc(chunk_of(f, 4), 1'b0, 1'b1);
    bus_if.frame_ready = 1'b0;
    want_f = exp_frames.pop_front();
    cur_frame = want_f;
    n_cmp++; if (bus_if.pin_out !== 8'h40) begin n_err++; $display("FAIL ow_sv_clear: got %h want 40", bus_if.pin_out); end
    n_cmp++; if (bus_if.frame_data !== want_f) begin n_err++; $display("FAIL ow_fdata2: got %h want %h", bus_if.frame_data, want_f); end
  endtask

  task automatic test_restart;
    logic [29:0] f;
    cyc(6'h0A, 1'b0, 1'b1);
    cyc(6'h0B, 1'b0, 1'b0);
    cyc(6'h3F, 1'b1, 1'b0);
    n_cmp++; if (bus_if.slot !== 3'd0) begin n_err++; $display("FAIL rs_slot: got %0d want 0", bus_if.slot); end
    n_cmp++; if (bus_if.frame_valid !== 1'b0) begin n_err++; $display("FAIL rs_fv: got %b want 0", bus_if.frame_valid); end
    f = {6'h25, 6'h24, 6'h23, 6'h22, 6'h21};
    exp_frames.push_back(f);
    drive_frame(f, 5'b00000);
    want_f = exp_frames.pop_front();
    cur_frame = want_f;
    n_cmp++; if (bus_if.frame_data !== want_f) begin n_err++; $display("FAIL rs_fdata: got %h want %h", bus_if.frame_data, want_f); end
    // Restart in the last slot: no completion and no acknowledge.
    bus_if.out_valid = 1'b1;
    bus_if.out_word  = 32'h12345678;
    for (int k = 0; k < 4; k++) cyc(6'h3F, 1'b0, 1'b0);
    bus_if.pin_data = 6'h3F;
    bus_if.restart  = 1'b1;
    #1;
    n_cmp++; if (bus_if.out_ack !== 1'b0) begin n_err++; $display("FAIL rs_last_ack: got %b want 0", bus_if.out_ack); end
    @(posedge clk);
    #1;
    bus_if.restart   = 1'b0;
    bus_if.out_valid = 1'b0;
    n_cmp++; if (bus_if.slot !== 3'd0) begin n_err++; $display("FAIL rs_last_slot: got %0d want 0", bus_if.slot); end
    n_cmp++; if (bus_if.overrun !== 1'b0) begin n_err++; $display("FAIL rs_last_ovr: got %b want 0", bus_if.overrun); end
    n_cmp++; if (bus_if.frame_data !== cur_frame) begin n_err++; $display("FAIL rs_last_keep: got %h want %h", bus_if.frame_data, cur_frame); end
    n_cmp++; if (bus_if.pin_out !== 8'h40) begin n_err++; $display("FAIL rs_last_status: got %h want 40", bus_if.pin_out); end
  endtask

  task automatic test_async_reset;
    for (int k = 0; k < 3; k++) cyc(6'h15, 1'b0, 1'b0);
    n_cmp++; if (bus_if.slot !== 3'd3) begin n_err++; $display("FAIL ar_pre_slot: got %0d want 3", bus_if.slot); end
    n_cmp++; if (bus_if.pin_out !== 8'hAD) begin n_err++; $display("FAIL ar_held_byte: got %h want ad", bus_if.pin_out); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (bus_if.slot !== 3'd0) begin n_err++; $display("FAIL ar_slot: got %0d want 0", bus_if.slot); end
    n_cmp++; if (bus_if.frame_valid !== 1'b0) begin n_err++; $display("FAIL ar_fv: got %b want 0", bus_if.frame_valid); end
    n_cmp++; if (bus_if.frame_data !== 30'h0) begin n_err++; $display("FAIL ar_fdata: got %h want 0", bus_if.frame_data); end
    n_cmp++; if (bus_if.pin_out !== 8'h00) begin n_err++; $display("FAIL ar_pin_out: got %h want 00", bus_if.pin_out); end
    n_cmp++; if (bus_if.out_ack !== 1'b0) begin n_err++; $display("FAIL ar_ack: got %b want 0", bus_if.out_ack); end
    reset = 1'b0;
    cyc(6'h01, 1'b0, 1'b0);
    n_cmp++; if (bus_if.slot !== 3'd1) begin n_err++; $display("FAIL ar_restart_slot: got %0d want 1", bus_if.slot); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_overrun();
    test_back_to_back();
    test_out_word();
    test_restart();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
